mem_access_unit: RTL and testbench

MEM-stage data-memory access unit of the RISC-V core. Consumes the memory-access fields presented at the output of the EX/MEM pipeline register: address, store data, read/write strobes and access type. It drives a request/grant/response data-memory port and formats load data for the MEM/WB register. It stalls the front of the pipeline (holds EX/MEM) until the access completes.

---
 rtl/riscv_mem_pkg.sv | 30 +++
 rtl/mem_load_formatter.sv | 33 +++
 rtl/mem_access_unit.sv | 126 ++++++++++++
 tb/tb_mem_access_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access path:
// funct3 encodings, the access FSM states and byte-enable generation.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } memState_e;

  // Access width lives in funct3[1:0]; the lane comes from the low address bits.
  function automatic logic [3:0] byteEnable(input logic [2:0] funct3, input logic [1:0] addrLsb);
    case (funct3[1:0])
      2'b00:   byteEnable = 4'b0001 << addrLsb;
      2'b01:   byteEnable = addrLsb[1] ? 4'b1100 : 4'b0011;
      default: byteEnable = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_formatter.sv
// Picks the addressed byte/halfword lane out of a read word and
// sign- or zero-extends it according to the load type.
module mem_load_formatter
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Lane selection followed by extension; unknown types pass the word through.
  always_comb begin
    case (addr_i)
      2'b00:   byteSel = rdata_i[7:0];
      2'b01:   byteSel = rdata_i[15:8];
      2'b10:   byteSel = rdata_i[23:16];
      default: byteSel = rdata_i[31:24];
    endcase
    halfSel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{byteSel[7]}}, byteSel};
      F3_LH:   data_o = {{16{halfSel[15]}}, halfSel};
      F3_LBU:  data_o = {24'h0, byteSel};
      F3_LHU:  data_o = {16'h0, halfSel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: checks the EX/MEM access for legality,
// runs the req/gnt/rvalid handshake, and returns formatted load data while
// holding the front of the pipeline.
module mem_access_unit
  import riscv_mem_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        valid_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  LoadOrStoreTYPE_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] StoreData_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        access_fault_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  memState_e   state_q;
  logic        isLoad_q;
  logic [1:0]  addrLsb_q;
  logic [2:0]  funct3_q;

  logic        opPresent;
  logic        loadTypeOk;
  logic        storeTypeOk;
  logic        misaligned;
  logic        fault;
  logic        legalOp;
  logic [31:0] wdata_d;
  logic [31:0] formatted;

  // Decide whether the presented op is legal and build the replicated store data.
  always_comb begin
    opPresent   = valid_i & (MemRead_i | MemWrite_i);
    loadTypeOk  = (LoadOrStoreTYPE_i == F3_LB)  || (LoadOrStoreTYPE_i == F3_LH) ||
                  (LoadOrStoreTYPE_i == F3_LW)  || (LoadOrStoreTYPE_i == F3_LBU) ||
                  (LoadOrStoreTYPE_i == F3_LHU);
    storeTypeOk = (LoadOrStoreTYPE_i == F3_SB)  || (LoadOrStoreTYPE_i == F3_SH) ||
                  (LoadOrStoreTYPE_i == F3_SW);
    misaligned  = ((LoadOrStoreTYPE_i[1:0] == 2'b01) && ALUResult_i[0]) ||
                  ((LoadOrStoreTYPE_i[1:0] == 2'b10) && (ALUResult_i[1:0] != 2'b00));
    fault       = opPresent & ((MemRead_i & MemWrite_i) |
                               (MemRead_i & ~loadTypeOk) |
                               (MemWrite_i & ~storeTypeOk) |
                               misaligned);
    legalOp     = opPresent & ~fault;
    case (LoadOrStoreTYPE_i[1:0])
      2'b00:   wdata_d = {4{StoreData_i[7:0]}};
      2'b01:   wdata_d = {2{StoreData_i[15:0]}};
      default: wdata_d = StoreData_i;
    endcase
  end

  // Stall and fault must act in the same cycle the op is seen, so they stay combinational.
  assign stall_o        = ~RESET & (((state_q == IDLE) & legalOp) | (state_q == REQ) | (state_q == RESP));
  assign access_fault_o = ~RESET & (state_q == IDLE) & fault;

  mem_load_formatter uFormatter (
    .rdata_i  (dmem_rdata),
    .addr_i   (addrLsb_q),
    .funct3_i (funct3_q),
    .data_o   (formatted)
  );

  // Access FSM with registered memory-port and load-result outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      isLoad_q     <= 1'b0;
      addrLsb_q    <= 2'b00;
      funct3_q     <= 3'b000;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_be      <= 4'h0;
      dmem_wdata   <= 32'h0;
      load_data_o  <= 32'h0;
      load_valid_o <= 1'b0;
    end else begin
      load_valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (legalOp) begin
            state_q    <= REQ;
            isLoad_q   <= MemRead_i;
            addrLsb_q  <= ALUResult_i[1:0];
            funct3_q   <= LoadOrStoreTYPE_i;
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_i;
            dmem_addr  <= {ALUResult_i[31:2], 2'b00};
            dmem_be    <= byteEnable(LoadOrStoreTYPE_i, ALUResult_i[1:0]);
            dmem_wdata <= wdata_d;
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            state_q  <= isLoad_q ? RESP : DONE;
          end
        end
        RESP: begin
          if (dmem_rvalid) begin
            load_data_o  <= formatted;
            load_valid_o <= 1'b1;
            state_q      <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a vector table of accesses with
// hand-computed expectations, a load-data scoreboard, and a reset-in-RESP case.
module tb_mem_access_unit;

  logic        CLK;
  logic        RESET;
  logic        valid_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [2:0]  LoadOrStoreTYPE_i;
  logic [31:0] ALUResult_i;
  logic [31:0] StoreData_i;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        load_valid_o;
  logic        access_fault_o;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          gntDelay;
    logic        expFault;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expLoad;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] expQ[$];
  int          checks;
  int          failures;

  mem_access_unit dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .valid_i           (valid_i),
    .MemRead_i         (MemRead_i),
    .MemWrite_i        (MemWrite_i),
    .LoadOrStoreTYPE_i (LoadOrStoreTYPE_i),
    .ALUResult_i       (ALUResult_i),
    .StoreData_i       (StoreData_i),
    .stall_o           (stall_o),
    .load_data_o       (load_data_o),
    .load_valid_o      (load_valid_o),
    .access_fault_o    (access_fault_o),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_be           (dmem_be),
    .dmem_wdata        (dmem_wdata),
    .dmem_gnt          (dmem_gnt),
    .dmem_rvalid       (dmem_rvalid),
    .dmem_rdata        (dmem_rdata)
  );

  // Free-running core clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    valid_i     = 1'b0;
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int  stallCycles;
    bit  finished;
    bit  isLoad;
    logic [31:0] expData;
    isLoad = v.rd && !v.wr;
    @(posedge CLK); #1;
    valid_i           = 1'b1;
    MemRead_i         = v.rd;
    MemWrite_i        = v.wr;
    LoadOrStoreTYPE_i = v.f3;
    ALUResult_i       = v.addr;
    StoreData_i       = v.sdata;
    dmem_gnt          = 1'b0;
    dmem_rvalid       = 1'b0;
    if (!v.expFault && isLoad) expQ.push_back(v.expLoad);
    @(negedge CLK);
    checkOutput({tag, " fault"}, access_fault_o, v.expFault);
    checkOutput({tag, " stall0"}, stall_o, !v.expFault);
    stallCycles = stall_o ? 1 : 0;
    if (v.expFault) begin
      @(posedge CLK); #1;
      idleInputs();
      @(negedge CLK);
      checkOutput({tag, " noreq"}, dmem_req, 1'b0);
      return;
    end
    finished = 0;
    for (int cyc = 1; cyc <= 30 && !finished; cyc++) begin
      @(posedge CLK); #1;
      dmem_gnt    = (cyc == 1 + v.gntDelay);
      dmem_rvalid = (cyc < 1 + v.gntDelay) || (isLoad && cyc == 2 + v.gntDelay);
      dmem_rdata  = (isLoad && cyc == 2 + v.gntDelay) ? v.rdata : 32'hBAD0BAD0;
      @(negedge CLK);
      if (cyc == 1) begin
        checkOutput({tag, " we"}, dmem_we, v.wr);
        checkOutput({tag, " addr"}, dmem_addr, {v.addr[31:2], 2'b00});
        if (v.wr) begin
          checkOutput({tag, " be"}, dmem_be, v.expBe);
          checkOutput({tag, " wdata"}, dmem_wdata, v.expWdata);
        end
      end
      if (cyc <= 1 + v.gntDelay) checkOutput({tag, " reqheld"}, dmem_req, 1'b1);
      if (isLoad && cyc == 2 + v.gntDelay) checkOutput({tag, " reqresp"}, dmem_req, 1'b0);
      if (stall_o) begin
        stallCycles++;
      end else begin
        finished = 1;
        checkOutput({tag, " stallcount"}, stallCycles, (isLoad ? 3 : 2) + v.gntDelay);
        checkOutput({tag, " lvalid"}, load_valid_o, isLoad);
        if (load_valid_o) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s scoreboard: load_valid with empty queue", tag);
          end else begin
            expData = expQ.pop_front();
            checkOutput({tag, " ldata"}, load_data_o, expData);
          end
        end
      end
    end
    if (!finished) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout: stall_o still 1 after 30 cycles, expected 0", tag);
    end
    @(posedge CLK); #1;
    idleInputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idleInputs();
    LoadOrStoreTYPE_i = 3'b000;
    ALUResult_i       = 32'h0;
    StoreData_i       = 32'h0;
    RESET             = 1'b1;

    // rd wr f3 addr sdata rdata gntDelay fault be wdata load
    vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h80FF_FF7F, 0, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80});
    vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'h0, 32'h80FF_FF7F, 0, 1'b0, 4'b0000, 32'h0, 32'h0000_0080});
    vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 2, 1'b0, 4'b0000, 32'h0, 32'h0000_8001});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_3001, 32'h1111_2222, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_4002, 32'h1234_56AB, 32'h0, 0, 1'b0, 4'b0100, 32'hABAB_ABAB, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_4002, 32'hCAFE_1234, 32'h0, 1, 1'b0, 4'b1100, 32'h1234_1234, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_5002, 32'h0, 32'h8001_7FFF, 0, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8001});
    vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_5000, 32'h0, 32'h8001_7FFF, 0, 1'b0, 4'b0000, 32'h0, 32'h0000_7FFF});
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h1357_9BDF, 1, 1'b0, 4'b0000, 32'h0, 32'h1357_9BDF});
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_6002, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h0000_7000, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h0000_7000, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_2001, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_7001, 32'h0000_00C3, 32'h0, 1, 1'b0, 4'b0010, 32'hC3C3_C3C3, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_7001, 32'h0, 32'h0000_7F00, 0, 1'b0, 4'b0000, 32'h0, 32'h0000_007F});

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst stall", stall_o, 1'b0);
    checkOutput("rst req", dmem_req, 1'b0);
    checkOutput("rst we", dmem_we, 1'b0);
    checkOutput("rst lvalid", load_valid_o, 1'b0);
    checkOutput("rst fault", access_fault_o, 1'b0);
    checkOutput("rst addr", dmem_addr, 32'h0);
    checkOutput("rst be", dmem_be, 4'h0);
    checkOutput("rst wdata", dmem_wdata, 32'h0);
    checkOutput("rst ldata", load_data_o, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // A load request with valid_i low is a bubble and must be ignored.
    MemRead_i         = 1'b1;
    LoadOrStoreTYPE_i = 3'b010;
    ALUResult_i       = 32'h0000_0040;
    @(negedge CLK);
    checkOutput("bubble stall", stall_o, 1'b0);
    @(posedge CLK); #1;
    idleInputs();
    @(negedge CLK);
    checkOutput("bubble req", dmem_req, 1'b0);

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("v%0d", i));

    // Reset while waiting in RESP; the late response must be dropped.
    @(posedge CLK); #1;
    valid_i           = 1'b1;
    MemRead_i         = 1'b1;
    LoadOrStoreTYPE_i = 3'b010;
    ALUResult_i       = 32'h0000_8000;
    @(negedge CLK);
    checkOutput("rr stall0", stall_o, 1'b1);
    @(posedge CLK); #1;
    dmem_gnt = 1'b1;
    @(negedge CLK);
    checkOutput("rr req", dmem_req, 1'b1);
    @(posedge CLK); #1;
    dmem_gnt = 1'b0;
    @(negedge CLK);
    checkOutput("rr respreq", dmem_req, 1'b0);
    checkOutput("rr respstall", stall_o, 1'b1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    idleInputs();
    @(negedge CLK);
    checkOutput("rr idle stall", stall_o, 1'b0);
    checkOutput("rr idle req", dmem_req, 1'b0);
    @(posedge CLK); #1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    @(posedge CLK); #1;
    idleInputs();
    @(negedge CLK);
    checkOutput("rr late lvalid", load_valid_o, 1'b0);
    checkOutput("rr late ldata", load_data_o, 32'h0);

    checkOutput("scoreboard empty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
